// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter.
//
// Shares one Wishbone master port on the interconnect between master 0 (CPU core)
// and master 1 (debugger UART master). A grant is held for the whole bus cycle
// (cyc high), so block transfers and read-modify-write sequences are atomic.
// Simultaneous requests from idle are resolved round-robin. A per-transfer
// timeout ends a strobe that is never acked with an error, so the debugger can
// always get the bus back.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-low reset
//   m0_* / m1_* inputs     master address, write data, byte selects, we, cyc, stb
//   m0_dat_o / m1_dat_o    read data (both are copies of s_dat_i)
//   m0_ack_o / m1_ack_o    ack, routed to the granted master only
//   m0_err_o / m1_err_o    timeout error, routed to the granted master only
//   s_* outputs            muxed master signals towards the interconnect
//   s_dat_i, s_ack_i       read data and ack from the interconnect
//   gnt_o                  one-hot current grant (bit 0 = master 0)
//   timeout_o              one-cycle pulse on a forced termination
module wb_arbiter2 #(
    parameter int unsigned DW      = 16,
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,

    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,

    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,

    output logic [1:0]      gnt_o,
    output logic            timeout_o
);

    // The counter only ever reaches TIMEOUT-1 before clearing, so it never saturates.
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CntMax = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;   // master that most recently released the bus
    logic [CW-1:0] cnt_q, cnt_d;

    logic req_cyc;
    logic req_stb;
    logic timeout_now;

    // State, pointer and timeout counter registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            last_q  <= 1'b1;          // master 0 wins the first tie
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state / grant logic
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? StGnt0 : StGnt1;
                end else if (m0_cyc_i) begin
                    state_d = StGnt0;
                end else if (m1_cyc_i) begin
                    state_d = StGnt1;
                end
            end
            StGnt0: begin
                if (!m0_cyc_i) begin
                    last_d  = 1'b0;
                    // Hand straight over to a waiting master, no idle bubble
                    state_d = m1_cyc_i ? StGnt1 : StIdle;
                end
            end
            StGnt1: begin
                if (!m1_cyc_i) begin
                    last_d  = 1'b1;
                    state_d = m0_cyc_i ? StGnt0 : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus muxes driven from the registered grant
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        req_cyc = 1'b0;
        req_stb = 1'b0;
        unique case (state_q)
            StGnt0: begin
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_sel_o = m0_sel_i;
                s_we_o  = m0_we_i;
                req_cyc = m0_cyc_i;
                req_stb = m0_stb_i;
            end
            StGnt1: begin
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_sel_o = m1_sel_i;
                s_we_o  = m1_we_i;
                req_cyc = m1_cyc_i;
                req_stb = m1_stb_i;
            end
            default: ;
        endcase
    end

    // An ack in the threshold cycle wins over the timeout
    assign timeout_now = req_cyc & req_stb & ~s_ack_i & (cnt_q == CntMax);

    assign s_cyc_o   = req_cyc;
    assign s_stb_o   = req_cyc & req_stb & ~timeout_now;
    assign timeout_o = timeout_now;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = (state_q == StGnt0) & s_ack_i;
    assign m1_ack_o = (state_q == StGnt1) & s_ack_i;
    assign m0_err_o = (state_q == StGnt0) & timeout_now;
    assign m1_err_o = (state_q == StGnt1) & timeout_now;

    assign gnt_o = {state_q == StGnt1, state_q == StGnt0};

    // Counts wait cycles of the current strobe; an abandoned strobe (cyc or stb
    // dropped), an ack, a forced termination or a grant change all restart it.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (!(req_cyc && req_stb) || s_ack_i || timeout_now) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
module tb_wb_arbiter2;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 32;
    localparam int unsigned TO = 8;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic [AW-1:0]   m0_adr_i = '0, m1_adr_i = '0;
    logic [DW-1:0]   m0_dat_i = '0, m1_dat_i = '0;
    logic [DW/8-1:0] m0_sel_i = '0, m1_sel_i = '0;
    logic            m0_we_i = 1'b0, m1_we_i = 1'b0;
    logic            m0_cyc_i = 1'b0, m1_cyc_i = 1'b0;
    logic            m0_stb_i = 1'b0, m1_stb_i = 1'b0;
    logic [DW-1:0]   m0_dat_o, m1_dat_o;
    logic            m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [DW/8-1:0] s_sel_o;
    logic            s_we_o, s_cyc_o, s_stb_o;
    logic [DW-1:0]   s_dat_i = '0;
    logic            s_ack_i = 1'b0;
    logic [1:0]      gnt_o;
    logic            timeout_o;

    wb_arbiter2 #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .gnt_o(gnt_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          m;
        logic [15:0] dat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge, outputs are sampled 1 later
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_ack(input int m, input logic [15:0] d);
        exp_t e;
        e.m   = m;
        e.dat = d;
        sb.push_back(e);
    endtask

    // Slave acks this cycle; the scoreboard says which master must see it
    task automatic slave_ack(input string tag, input logic [15:0] d);
        exp_t e;
        int   who;
        s_ack_i = 1'b1;
        s_dat_i = d;
        #1;
        check({tag, "_sb"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            who = (m0_ack_o && m1_ack_o) ? 2 : m0_ack_o ? 0 : m1_ack_o ? 1 : -1;
            check({tag, "_who"}, 64'(who), 64'(e.m));
            check({tag, "_dat"}, 64'(e.m == 0 ? m0_dat_o : m1_dat_o), 64'(e.dat));
            check({tag, "_err"}, 64'(m0_err_o | m1_err_o), 64'd0);
        end
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_gnt", 64'(gnt_o), 64'd0);
        check("rst_cyc", 64'(s_cyc_o), 64'd0);
        check("rst_to", 64'(timeout_o), 64'd0);
        #10 rst_i = 1'b1;

        // Tie right after reset: master 0 first, then master 1 with no idle cycle
        step();
        m0_adr_i = 32'h0000_0100; m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_sel_i = 2'b11;
        m1_adr_i = 32'h0000_0200; m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_sel_i = 2'b11;
        #1;
        check("tie_idle_gnt", 64'(gnt_o), 64'd0);
        check("tie_idle_adr", 64'(s_adr_o), 64'd0);
        step();
        #1;
        check("tie_gnt0", 64'(gnt_o), 64'b01);
        check("tie_adr0", 64'(s_adr_o), 64'h100);
        step();
        expect_ack(0, 16'h1111);
        slave_ack("tie_a0", 16'h1111);
        step();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        #1;
        check("tie_m1_noack", 64'(m1_ack_o), 64'd0);
        step();
        #1;
        check("tie_gnt1", 64'(gnt_o), 64'b10);
        check("tie_adr1", 64'(s_adr_o), 64'h200);
        expect_ack(1, 16'h2222);
        slave_ack("tie_a1", 16'h2222);
        step();
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        step();
        #1;
        check("tie_end_idle", 64'(gnt_o), 64'd0);

        // Round robin: both masters keep re-requesting after each single transfer
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("rr%0d_gnt", i), 64'(gnt_o), (i % 2 == 0) ? 64'b01 : 64'b10);
            expect_ack(i % 2, 16'hA000 + 16'(i));
            slave_ack($sformatf("rr%0d", i), 16'hA000 + 16'(i));
            step();
            s_ack_i = 1'b0;
            if (i % 2 == 0) begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
            else begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
            step();
            if (i < 4) begin
                if (i % 2 == 0) begin m0_cyc_i = 1'b1; m0_stb_i = 1'b1; end
                else begin m1_cyc_i = 1'b1; m1_stb_i = 1'b1; end
            end
        end
        #1;
        check("rr_end_idle", 64'(gnt_o), 64'd0);

        // Single master read: cyc at cycle 0, s_cyc at 1, ack at 2
        step();
        m0_adr_i = 32'h0000_1000; m0_we_i = 1'b0; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        #1;
        check("rd_c0_cyc", 64'(s_cyc_o), 64'd0);
        step();
        #1;
        check("rd_c1_cyc", 64'(s_cyc_o), 64'd1);
        check("rd_c1_stb", 64'(s_stb_o), 64'd1);
        check("rd_c1_adr", 64'(s_adr_o), 64'h1000);
        check("rd_c1_gnt", 64'(gnt_o), 64'b01);
        check("rd_c1_ack", 64'(m0_ack_o), 64'd0);
        step();
        expect_ack(0, 16'hBEEF);
        slave_ack("rd_c2", 16'hBEEF);
        step();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        #1;
        check("rd_drop_cyc", 64'(s_cyc_o), 64'd0);
        step();
        #1;
        check("rd_idle", 64'(gnt_o), 64'd0);

        // Atomicity: m0 holds cyc over 4 strobes while m1 waits
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        step();
        m1_adr_i = 32'h0000_0300; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            m0_adr_i = 32'h0000_2000 + 32'(2 * k);
            #1;
            check($sformatf("at%0d_gnt", k), 64'(gnt_o), 64'b01);
            check($sformatf("at%0d_adr", k), 64'(s_adr_o), 64'h2000 + 64'(2 * k));
            expect_ack(0, 16'hC000 + 16'(k));
            slave_ack($sformatf("at%0d", k), 16'hC000 + 16'(k));
            step();
            s_ack_i = 1'b0;
        end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        #1;
        check("at_hold", 64'(gnt_o), 64'b01);
        step();
        #1;
        check("at_m1_gnt", 64'(gnt_o), 64'b10);
        expect_ack(1, 16'h3333);
        slave_ack("at_m1", 16'h3333);
        step();
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        step();

        // Timeout: unmapped strobe, error in the 8th cycle of s_stb_o
        m1_adr_i = 32'hF000_0020; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        step();
        for (int n = 1; n <= 9; n++) begin
            #1;
            check($sformatf("to%0d_err", n), 64'(m1_err_o), (n == 8) ? 64'd1 : 64'd0);
            check($sformatf("to%0d_pulse", n), 64'(timeout_o), (n == 8) ? 64'd1 : 64'd0);
            check($sformatf("to%0d_stb", n), 64'(s_stb_o), (n == 8) ? 64'd0 : 64'd1);
            check($sformatf("to%0d_ack", n), 64'(m1_ack_o), 64'd0);
            check($sformatf("to%0d_m0err", n), 64'(m0_err_o), 64'd0);
            check($sformatf("to%0d_gnt", n), 64'(gnt_o), 64'b10);
            step();
        end
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        step();
        // Ack in the threshold cycle wins over the timeout
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        step();
        repeat (7) step();
        expect_ack(1, 16'h4444);
        slave_ack("to_race", 16'h4444);
        check("to_race_pulse", 64'(timeout_o), 64'd0);
        step();
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        step();

        // Asynchronous reset in the middle of an m0 write
        m0_adr_i = 32'h0000_4000; m0_dat_i = 16'h1234; m0_we_i = 1'b1;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        step();
        #1;
        check("ar_pre_cyc", 64'(s_cyc_o), 64'd1);
        check("ar_pre_we", 64'(s_we_o), 64'd1);
        check("ar_pre_dat", 64'(s_dat_o), 64'h1234);
        #1 rst_i = 1'b0;
        #1;
        check("ar_cyc", 64'(s_cyc_o), 64'd0);
        check("ar_stb", 64'(s_stb_o), 64'd0);
        check("ar_gnt", 64'(gnt_o), 64'd0);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
        #1 rst_i = 1'b1;
        step();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        step();
        #1;
        check("ar_tie_gnt", 64'(gnt_o), 64'b01);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        step();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
Two-master Wishbone arbiter that shares the single master port of the SoC bus interconnect between the moxielite_wb core (master 0) and the GDB target-engine UART master (master 1). Grants are held for a whole Wishbone cycle (cyc asserted) and rotate round-robin when both masters request. A per-transfer timeout terminates hung strobes with an error so the debugger can always regain the bus. The block sits between the two masters and the wbm_* side of wb_intercon.

Parameters:
DW, 16, data bus width
AW, 32, address bus width
TIMEOUT, 255, cycles a strobe may wait for ack before forced error termination (1..65535)

Ports:
clk_i  in  1  system clock (clk_cpu)
rst_i  in  1  asynchronous active-low reset
m0_adr_i / m1_adr_i  in  AW  master address
m0_dat_i / m1_dat_i  in  DW  master write data
m0_sel_i / m1_sel_i  in  DW/8  byte selects
m0_we_i / m1_we_i  in  1  write enable
m0_cyc_i / m1_cyc_i  in  1  bus cycle request
m0_stb_i / m1_stb_i  in  1  strobe
m0_dat_o / m1_dat_o  out  DW  read data (shared copy of s_dat_i)
m0_ack_o / m1_ack_o  out  1  ack, granted master only
m0_err_o / m1_err_o  out  1  timeout error, granted master only
s_adr_o  out  AW  address to interconnect
s_dat_o  out  DW  write data to interconnect
s_sel_o  out  DW/8  byte selects to interconnect
s_we_o  out  1  write enable to interconnect
s_cyc_o  out  1  cycle to interconnect
s_stb_o  out  1  strobe to interconnect
s_dat_i  in  DW  read data from interconnect
s_ack_i  in  1  ack from interconnect
gnt_o  out  2  one-hot current grant, for debug LEDs
timeout_o  out  1  one-cycle pulse on forced termination

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE, gnt_o=2'b00, last-grant pointer = 1 (so master 0 wins first tie), timeout counter 0, timeout_o=0. All s_* outputs are 0 while no grant; m*_ack_o/m*_err_o 0.
- States: IDLE, GNT0, GNT1. Grant is registered; s_* signals and ack/err routing are combinational muxes of the registered grant.
- IDLE: if only m0_cyc_i -> GNT0; only m1_cyc_i -> GNT1; both -> grant master NOT equal to last pointer. Arbitration latency: exactly 1 cycle from cyc assertion to s_cyc_o.
- GNTn: s_adr/dat/sel/we/cyc/stb = master n signals; s_stb_o = mn_stb_i & mn_cyc_i & ~timeout_now. mn_ack_o = s_ack_i; other master's ack/err held 0. Both m*_dat_o = s_dat_i.
- Leave GNTn when mn_cyc_i deasserts: pointer := n; if the other master's cyc is high go directly to its GNT state in the same edge (no idle bubble), else IDLE. Grant never changes while granted cyc high (block transfers and RMW are atomic).
- Timeout counter: increments each cycle s_stb_o high and s_ack_i low; clears on s_ack_i, on stb low, and on grant change. When counter == TIMEOUT-1 and no ack that cycle: timeout_now=1 for that cycle -> mn_err_o=1, mn_ack_o=0, s_stb_o forced 0, timeout_o=1; counter clears. Master keeps grant until it drops cyc.
- Simultaneous ack and timeout-threshold: ack wins, no error.
- Counter width ceil(log2(TIMEOUT+1)); saturation never reached.
- Reset mid-transfer: grant drops immediately, s_cyc_o/s_stb_o go 0 asynchronously.
- Master dropping cyc with stb high and no ack: transfer abandoned, no error, counter clears.

Test Plan:
- Single master: m0 read 0x00001000 cyc/stb at cycle 0, slave acks cycle 2 with 0xBEEF -> s_cyc_o high from cycle 1, m0_ack_o at cycle 2, m0_dat_o=0xBEEF, m1_ack_o stays 0, gnt_o=01.
- Tie after reset: m0 and m1 cyc asserted same cycle -> gnt_o=01 first; m0 drops cyc, m1 still requesting -> gnt_o=10 next edge with no IDLE cycle.
- Round-robin: both masters continuously re-request after each 1-ack cycle for 6 transfers -> grants alternate 01,10,01,10,01,10.
- Atomicity: m0 holds cyc over 4 strobes while m1 requests -> gnt_o stays 01 for all 4 acks; m1 granted only after m0 cyc low.
- Timeout with TIMEOUT=8: m1 strobes 0xF0000020 (unmapped, never acked) -> m1_err_o and timeout_o pulse exactly 8 cycles after s_stb_o rose, s_stb_o low that cycle, m1_ack_o never asserted.
- Async reset: rst_i low mid-write from m0 -> s_cyc_o, s_stb_o, gnt_o 0 same cycle without a clock edge; after release, first tie grants m0.
